// File: rtl/div.sv
// ---------------------------------------------------------------------------
// div -- iterative 32-bit signed/unsigned divider (restoring, 1 bit/cycle)
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   rst          : synchronous active-high reset (priority over everything)
//   signed_div_i : 1 = signed divide, 0 = unsigned; sampled at acceptance
//   opdata1_i    : dividend, sampled at acceptance
//   opdata2_i    : divisor, sampled at acceptance
//   start_i      : request, held high by the requester until ready_o is seen
//   annul_i      : cancels a division still in progress (ON / BYZERO)
//   result_o     : {remainder[63:32], quotient[31:0]}, registered
//   ready_o      : result_o valid, registered
//   dbg_state    : current FSM state (FREE=0, BYZERO=1, ON=2, END=3)
//
// Handshake: a request is accepted on the first rising edge in FREE where
// start_i=1 and annul_i=0. ready_o then stays high (with result_o stable)
// for as long as start_i is held; the edge after start_i drops returns the
// divider to FREE with ready_o=0 and result_o=0.
//
// Configuration
//   DIV_BYZERO_FAST_EN : when defined, a zero divisor skips the iteration
//                        through the BYZERO state and returns result_o=0.
//                        When undefined, a zero divisor runs the normal
//                        32-step iteration (quotient all ones).
// ---------------------------------------------------------------------------
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
`ifdef DIV_BYZERO_FAST_EN
    BYZERO = 2'd1,
`endif
    ON     = 2'd2,
    END    = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [5:0]  cnt, cnt_n;
  // {partial remainder (33 bits), dividend/quotient (32 bits)}
  logic [64:0] work, work_n;
  logic [31:0] dvs, dvs_n;          // divisor magnitude
  logic        neg_quot, neg_quot_n;
  logic        neg_rem, neg_rem_n;
  logic [63:0] result_n;
  logic        ready_n;

  // Operand magnitudes at acceptance time.
  logic [31:0] mag_a, mag_b;
  assign mag_a = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign mag_b = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  // One restoring step on the shifted working register.
  logic [64:0] shifted;
  logic [32:0] diff;
  logic        ge;
  assign shifted = work << 1;
  assign ge      = shifted[64:32] >= {1'b0, dvs};
  assign diff    = shifted[64:32] - {1'b0, dvs};

  // Sign correction applied once all 32 steps are done.
  logic [31:0] quot_fix, rem_fix;
  assign quot_fix = neg_quot ? (~work[31:0] + 32'd1)  : work[31:0];
  assign rem_fix  = neg_rem  ? (~work[63:32] + 32'd1) : work[63:32];

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    work_n     = work;
    dvs_n      = dvs;
    neg_quot_n = neg_quot;
    neg_rem_n  = neg_rem;
    result_n   = result_o;
    ready_n    = ready_o;

    case (state)
      FREE: begin
        result_n = 64'd0;
        ready_n  = 1'b0;
        if (start_i && !annul_i) begin
`ifdef DIV_BYZERO_FAST_EN
          if (opdata2_i == 32'd0) state_n = BYZERO;
          else
`endif
          begin
            state_n    = ON;
            cnt_n      = 6'd0;
            work_n     = {33'd0, mag_a};
            dvs_n      = mag_b;
            neg_quot_n = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
            // Remainder takes the sign of the dividend.
            neg_rem_n  = signed_div_i & opdata1_i[31];
          end
        end
      end

`ifdef DIV_BYZERO_FAST_EN
      BYZERO: begin
        if (annul_i) begin
          state_n  = FREE;
          result_n = 64'd0;
          ready_n  = 1'b0;
        end else begin
          state_n  = END;
          result_n = 64'd0;
          ready_n  = 1'b1;
        end
      end
`endif

      ON: begin
        if (annul_i) begin
          state_n  = FREE;
          result_n = 64'd0;
          ready_n  = 1'b0;
        end else if (cnt != 6'd32) begin
          // Quotient bit lands in the LSB freed by the shift.
          work_n = ge ? {diff, shifted[31:0] | 32'd1} : shifted;
          cnt_n  = cnt + 6'd1;
        end else begin
          state_n  = END;
          result_n = {rem_fix, quot_fix};
          ready_n  = 1'b1;
        end
      end

      END: begin
        // annul_i is deliberately ignored here; only dropping start_i exits.
        if (!start_i) begin
          state_n  = FREE;
          result_n = 64'd0;
          ready_n  = 1'b0;
        end
      end

      default: begin
        state_n  = FREE;
        result_n = 64'd0;
        ready_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= 6'd0;
      work     <= 65'd0;
      dvs      <= 32'd0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      result_o <= 64'd0;
      ready_o  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      work     <= work_n;
      dvs      <= dvs_n;
      neg_quot <= neg_quot_n;
      neg_rem  <= neg_rem_n;
      result_o <= result_n;
      ready_o  <= ready_n;
    end
  end

  assign dbg_state = state;

endmodule
